pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a data payload and a control bundle and uses a valid/ready handshake. It adds stall, flush and bubble insertion, plus an optional two-entry skid buffer that removes the combinational ready path. A saturating bubble counter supports performance debug.

---
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_if
//  Description : Valid/ready handshake bundle carrying a data payload and a
//                control bundle between pipeline stages.
//                  valid : entry present (producer -> consumer)
//                  ready : consumer accepts this cycle (consumer -> producer)
//                  data  : payload, WIDTH bits
//                  ctrl  : control bundle, CTRL_W bits
//                master = producer side, slave = consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [WIDTH-1:0]  data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Generic pipeline stage register with valid/ready handshake,
//                stall, flush, bubble insertion, optional two-entry skid
//                buffer and a saturating bubble counter.
//  Ports       : clk        - rising-edge clock
//                reset      - asynchronous active-low reset
//                up         - upstream handshake (slave: in_valid/in_ready/
//                             in_data/in_ctrl)
//                dn         - downstream handshake (master: out_valid/
//                             out_ready/out_data/out_ctrl)
//                stall      - freeze stage contents, present a bubble
//                flush      - discard all held entries at the next edge
//                occupancy  - number of entries held (0..2)
//                bubble_cnt - saturating count of bubble cycles
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    pipe_stage_reg_if.slave       up,
    pipe_stage_reg_if.master      dn,
    input  wire logic             stall,
    input  wire logic             flush,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      bubble_cnt
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_m_data;
    logic [CTRL_W-1:0]   r_m_ctrl;
    logic [WIDTH-1:0]    r_s_data;
    logic [CTRL_W-1:0]   r_s_ctrl;
    logic [CNT_W-1:0]    r_bubble_cnt;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_accept;
    logic                w_pop;

    // A stalled stage shows a bubble; contents stay put because neither
    // accept nor pop can fire while stall is high.
    assign w_out_valid = (r_state != ST_EMPTY) & ~stall;
    assign w_accept    = up.valid & w_in_ready;
    assign w_pop       = w_out_valid & dn.ready;

    // in_ready is additionally gated by the reset pin so it reads 0 while
    // reset is held, even though the state register already reads EMPTY.
    generate
        if (SKID != 0) begin : g_skid_ready
            // Depends on state only: no combinational path from out_ready.
            assign w_in_ready = (r_state != ST_TWO) & ~stall & reset;
        end else begin : g_comb_ready
            assign w_in_ready = ((r_state == ST_EMPTY) | dn.ready) & ~stall & reset;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_EMPTY;
            r_m_data <= '0;
            r_m_ctrl <= '0;
            r_s_data <= '0;
            r_s_ctrl <= '0;
        end else if (flush) begin
            r_state  <= ST_EMPTY;
            r_m_data <= '0;
            r_m_ctrl <= '0;
            r_s_data <= '0;
            r_s_ctrl <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_m_data <= up.data;
                        r_m_ctrl <= up.ctrl;
                        r_state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    // Without a skid register accept implies pop, so the
                    // first branch is only reachable in skid mode.
                    if (w_accept && !w_pop && (SKID != 0)) begin
                        r_s_data <= up.data;
                        r_s_ctrl <= up.ctrl;
                        r_state  <= ST_TWO;
                    end else if (w_accept) begin
                        r_m_data <= up.data;
                        r_m_ctrl <= up.ctrl;
                    end else if (w_pop) begin
                        // Payload is kept so out_data still shows M's value.
                        r_state  <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_m_data <= r_s_data;
                        r_m_ctrl <= r_s_ctrl;
                        r_state  <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // Counts cycles where downstream was ready but received nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bubble_cnt <= '0;
        end else if (!w_out_valid && dn.ready && !stall && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign up.ready   = w_in_ready;
    assign dn.valid   = w_out_valid;
    assign dn.data    = r_m_data;
    assign dn.ctrl    = w_out_valid ? r_m_ctrl : '0;
    assign occupancy  = r_state;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Directed self-checking bench. dut0 is the skid version with
//                a 16-bit counter, dut1 the single-register version with a
//                2-bit counter; both share the same stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic [15:0] in_ctrl;
    logic        out_ready;
    logic        stall;
    logic        flush;

    logic [1:0]  occ0;
    logic [1:0]  occ1;
    logic [15:0] bub0;
    logic [1:0]  bub1;

    int total;
    int bad;

    pipe_stage_reg_if #(.WIDTH(64), .CTRL_W(16)) up0 ();
    pipe_stage_reg_if #(.WIDTH(64), .CTRL_W(16)) dn0 ();
    pipe_stage_reg_if #(.WIDTH(64), .CTRL_W(16)) up1 ();
    pipe_stage_reg_if #(.WIDTH(64), .CTRL_W(16)) dn1 ();

    assign up0.valid = in_valid;
    assign up0.data  = in_data;
    assign up0.ctrl  = in_ctrl;
    assign dn0.ready = out_ready;
    assign up1.valid = in_valid;
    assign up1.data  = in_data;
    assign up1.ctrl  = in_ctrl;
    assign dn1.ready = out_ready;

    pipe_stage_reg #(.WIDTH(64), .CTRL_W(16), .SKID(1), .CNT_W(16)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .up         (up0),
        .dn         (dn0),
        .stall      (stall),
        .flush      (flush),
        .occupancy  (occ0),
        .bubble_cnt (bub0)
    );

    pipe_stage_reg #(.WIDTH(64), .CTRL_W(16), .SKID(0), .CNT_W(2)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .up         (up1),
        .dn         (dn1),
        .stall      (stall),
        .flush      (flush),
        .occupancy  (occ1),
        .bubble_cnt (bub1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;

        // ---------------- reset values ----------------
        #2;
        chk("rst_out_valid", 64'(dn0.valid), 64'd0);
        chk("rst_out_data",  dn0.data,       64'd0);
        chk("rst_out_ctrl",  64'(dn0.ctrl),  64'd0);
        chk("rst_in_ready",  64'(up0.ready), 64'd0);
        chk("rst_occ",       64'(occ0),      64'd0);
        chk("rst_bub",       64'(bub0),      64'd0);
        chk("rst_in_ready1", 64'(up1.ready), 64'd0);

        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rel_in_ready0", 64'(up0.ready), 64'd1);
        chk("rel_in_ready1", 64'(up1.ready), 64'd1);

        // ---------------- counter saturation ----------------
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("sat_bub1", 64'(bub1), (i > 3) ? 64'd3 : 64'(i));
            chk("sat_bub0", 64'(bub0), 64'(i));
        end

        // ---------------- streaming ----------------
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = 64'h10 + 64'(k);
            in_ctrl  = 16'(k + 1);
            tick();
            chk("str_valid0", 64'(dn0.valid), 64'd1);
            chk("str_data0",  dn0.data,       64'h10 + 64'(k));
            chk("str_ctrl0",  64'(dn0.ctrl),  64'(k + 1));
            chk("str_occ0",   64'(occ0),      64'd1);
            chk("str_data1",  dn1.data,       64'h10 + 64'(k));
            chk("str_occ1",   64'(occ1),      64'd1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("drain_occ",   64'(occ0),      64'd0);
        chk("drain_valid", 64'(dn0.valid), 64'd0);
        chk("drain_ctrl",  64'(dn0.ctrl),  64'd0);
        chk("drain_data",  dn0.data,       64'h1F);
        chk("drain_bub",   64'(bub0),      64'd7);

        // ---------------- backpressure (skid) ----------------
        in_valid = 1'b1;
        in_data  = 64'hA0;
        in_ctrl  = 16'hA;
        #1;
        chk("bp_rdy_empty", 64'(up0.ready), 64'd1);
        tick();
        chk("bp_occ_a",  64'(occ0),      64'd1);
        chk("bp_rdy_a",  64'(up0.ready), 64'd1);
        chk("bp_data_a", dn0.data,       64'hA0);
        in_data = 64'hB0;
        in_ctrl = 16'hB;
        tick();
        chk("bp_occ_b", 64'(occ0),      64'd2);
        chk("bp_rdy_b", 64'(up0.ready), 64'd0);
        in_data = 64'hC0;
        in_ctrl = 16'hC;
        tick();
        chk("bp_occ_c",  64'(occ0),      64'd2);
        chk("bp_head_a", dn0.data,       64'hA0);
        chk("bp_rdy_c",  64'(up0.ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_out1_valid", 64'(dn0.valid), 64'd1);
        chk("bp_out1",       dn0.data,       64'hA0);
        chk("bp_out1_ctrl",  64'(dn0.ctrl),  64'hA);
        tick();
        chk("bp_out2",     dn0.data,       64'hB0);
        chk("bp_out2_occ", 64'(occ0),      64'd1);
        chk("bp_out2_rdy", 64'(up0.ready), 64'd1);
        tick();
        chk("bp_out3",     dn0.data,       64'hC0);
        chk("bp_out3_occ", 64'(occ0),      64'd1);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("bp_end_occ", 64'(occ0), 64'd0);
        chk("bp_end_bub", 64'(bub0), 64'd7);

        // ---------------- stall ----------------
        in_valid = 1'b1;
        in_data  = 64'h77;
        in_ctrl  = 16'h3;
        tick();
        in_valid  = 1'b0;
        stall     = 1'b1;
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stl_valid", 64'(dn0.valid), 64'd0);
            chk("stl_ctrl",  64'(dn0.ctrl),  64'd0);
            chk("stl_rdy",   64'(up0.ready), 64'd0);
            chk("stl_occ",   64'(occ0),      64'd1);
            tick();
        end
        chk("stl_bub", 64'(bub0), 64'd7);
        stall     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("stl_rel_valid", 64'(dn0.valid), 64'd1);
        chk("stl_rel_data",  dn0.data,       64'h77);
        chk("stl_rel_ctrl",  64'(dn0.ctrl),  64'h3);

        // ---------------- flush ----------------
        in_valid = 1'b1;
        in_data  = 64'h88;
        in_ctrl  = 16'h4;
        tick();
        chk("fl_occ2", 64'(occ0), 64'd2);
        flush   = 1'b1;
        in_data = 64'h55;
        in_ctrl = 16'h5;
        #1;
        chk("fl_same_valid", 64'(dn0.valid), 64'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ",   64'(occ0),      64'd0);
        chk("fl_valid", 64'(dn0.valid), 64'd0);
        chk("fl_data",  dn0.data,       64'd0);
        chk("fl_ctrl",  64'(dn0.ctrl),  64'd0);
        out_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            tick();
            chk("fl_no55_valid", 64'(dn0.valid), 64'd0);
            chk("fl_no55_data",  dn0.data,       64'd0);
        end
        chk("fl_bub", 64'(bub0), 64'd9);
        out_ready = 1'b0;

        // ---------------- stall and flush together ----------------
        in_valid = 1'b1;
        in_data  = 64'h66;
        in_ctrl  = 16'h6;
        tick();
        chk("sf_occ_pre", 64'(occ0), 64'd1);
        in_valid = 1'b0;
        stall    = 1'b1;
        flush    = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        chk("sf_occ",   64'(occ0),      64'd0);
        chk("sf_valid", 64'(dn0.valid), 64'd0);

        // ---------------- asynchronous reset mid-stream ----------------
        in_valid = 1'b1;
        in_data  = 64'h91;
        in_ctrl  = 16'h9;
        tick();
        in_data = 64'h92;
        tick();
        chk("ar_occ_pre", 64'(occ0), 64'd2);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("ar_valid", 64'(dn0.valid), 64'd0);
        chk("ar_occ",   64'(occ0),      64'd0);
        chk("ar_rdy",   64'(up0.ready), 64'd0);
        chk("ar_bub",   64'(bub0),      64'd0);
        chk("ar_bub1",  64'(bub1),      64'd0);
        chk("ar_data",  dn0.data,       64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_rel_rdy", 64'(up0.ready), 64'd1);
        chk("ar_rel_occ", 64'(occ0),      64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
